// File: rtl/nand_stim_checker.sv
// nand_stim_checker: clocked stimulus/response checker for a 2-input NAND gate.
// Walks (w1,w2) through 00, 01, 10, 11 for REPEAT passes, samples c1 SETTLE_CYCLES
// after each vector is applied and counts mismatches against ~(w1 & w2).
// Optional: define NAND_CHK_FIRST_FAIL_EN to add first_fail_vld/first_fail_vec,
// which capture the vector index of the first mismatch of a run.
module nand_stim_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned REPEAT        = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             w1,
    output logic             w2,
    input  logic             c1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
`ifdef NAND_CHK_FIRST_FAIL_EN
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec,
`endif
    output logic [1:0]       vec_idx
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [7:0]       SettleInit = 8'(SETTLE_CYCLES);
    localparam logic [7:0]       LastPass   = 8'(REPEAT - 1);
    localparam logic [ERR_W-1:0] ErrMax     = '1;

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       pass_cnt_q, pass_cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic             w1_q, w1_d;
    logic             w2_q, w2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             accept;
    logic             mismatch;
`ifdef NAND_CHK_FIRST_FAIL_EN
    logic             ff_vld_q, ff_vld_d;
    logic [1:0]       ff_vec_q, ff_vec_d;
`endif

    // Next-state logic for the sequencer and every registered output.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        settle_d   = settle_q;
        w1_d       = w1_q;
        w2_d       = w2_q;
        err_d      = err_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        accept     = 1'b0;
        mismatch   = 1'b0;
`ifdef NAND_CHK_FIRST_FAIL_EN
        ff_vld_d   = ff_vld_q;
        ff_vec_d   = ff_vec_q;
`endif

        case (state_q)
            StIdle: begin
                accept = start;
            end
            StApply: begin
                busy_d   = 1'b1;
                w1_d     = vec_q[1];
                w2_d     = vec_q[0];
                settle_d = SettleInit;
                state_d  = (SETTLE_CYCLES > 0) ? StSettle : StSample;
            end
            StSettle: begin
                busy_d   = 1'b1;
                settle_d = settle_q - 8'd1;
                if (settle_q <= 8'd1) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                busy_d   = 1'b1;
                // Case inequality so that X/Z on c1 is scored as a mismatch.
                mismatch = (c1 !== ~(w1_q & w2_q));
                if (mismatch) begin
                    if (err_q != ErrMax) begin
                        err_d = err_q + ERR_W'(1);
                    end
`ifdef NAND_CHK_FIRST_FAIL_EN
                    if (!ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = vec_q;
                    end
`endif
                end
                if (vec_q == 2'd3 && pass_cnt_q == LastPass) begin
                    state_d = StDone;
                end else if (vec_q == 2'd3) begin
                    vec_d      = 2'd0;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    state_d    = StApply;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = StApply;
                end
            end
            StDone: begin
                accept = start;
                done_d = ~start;
                pass_d = ~start & (err_q == '0);
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Start acceptance clears the per-run state; w1/w2 keep their last vector.
        if (accept) begin
            state_d    = StApply;
            vec_d      = 2'd0;
            pass_cnt_d = 8'd0;
            err_d      = '0;
`ifdef NAND_CHK_FIRST_FAIL_EN
            ff_vld_d   = 1'b0;
            ff_vec_d   = 2'd0;
`endif
        end
    end

    // State and output registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            vec_q      <= 2'd0;
            pass_cnt_q <= 8'd0;
            settle_q   <= 8'd0;
            w1_q       <= 1'b0;
            w2_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
`ifdef NAND_CHK_FIRST_FAIL_EN
            ff_vld_q   <= 1'b0;
            ff_vec_q   <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
            settle_q   <= settle_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
`ifdef NAND_CHK_FIRST_FAIL_EN
            ff_vld_q   <= ff_vld_d;
            ff_vec_q   <= ff_vec_d;
`endif
        end
    end

    assign w1        = w1_q;
    assign w2        = w2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_idx   = vec_q;
`ifdef NAND_CHK_FIRST_FAIL_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
`endif

endmodule

// File: doc/nand_stim_checker.md
Name: nand_stim_checker

Overview:
- Self-checking stimulus/response stage wrapped around the 2-input NAND gate.
- Drives the gate's two inputs (w1, w2) through all four input combinations. Samples the gate output (c1) after a settle delay and compares it with the expected value ~(w1 & w2).
- Counts mismatches and reports busy/done/pass.
- Replaces free-running #delay stimulus with a clocked sequencer usable in simulation and on hardware.

Parameters:
- SETTLE_CYCLES, 1: idle cycles between applying a vector and sampling c1. Legal range 0..255.
- REPEAT, 1: number of full passes over the 4 vectors per run. Legal range 1..255.
- ERR_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  run request, sampled on clk; ignored while busy=1.
- w1  out  1  NAND input A; equals vector index bit 1.
- w2  out  1  NAND input B; equals vector index bit 0.
- c1  in  1  NAND output under test.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in DONE state; held until the next start.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  ERR_W  mismatch count for the current run; saturates at all-ones.
- vec_idx  out  2  current vector index 0..3.

Behaviour:
- Reset, asynchronous, active-high: the block enters IDLE and forces these values:
  - w1=0, w2=0, vec_idx=0
  - busy=0, done=0, pass=0, err_count=0
  - pass counter=0, settle counter=0
- Reset during a run aborts it immediately with no partial done.
- All outputs are registered.
- States:
  - IDLE: start=1 -> clear err_count, vec_idx, pass counter and done -> APPLY.
  - APPLY: register w1=vec_idx[1], w2=vec_idx[0]; load settle counter=SETTLE_CYCLES. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
  - SETTLE: decrement the settle counter; on the cycle it reaches 0 -> SAMPLE.
  - SAMPLE: compare c1 with ~(w1&w2) using a 4-state compare.
    - X or Z on c1 counts as a mismatch.
    - On mismatch, increment err_count by 1; no increment when already all-ones.
    - If vec_idx==3 and pass counter==REPEAT-1 -> DONE.
    - Else if vec_idx==3: vec_idx wraps to 0, pass counter +1 -> APPLY.
    - Else vec_idx +1 -> APPLY.
  - DONE: done=1, busy=0, pass=(err_count==0). start=1 -> same clearing as in IDLE -> APPLY.
- busy=1 in APPLY, SETTLE and SAMPLE.
- start while busy has no effect and is not queued.
- Latency:
  - Per vector: SETTLE_CYCLES+2 cycles.
  - Start accept to done rising: 4*REPEAT*(SETTLE_CYCLES+2)+1 cycles.
- w1/w2 hold their last vector (1,1) in DONE. They return to 0 only on reset.
- Vector order per pass is fixed: (w1,w2) = 00, 01, 10, 11.

Optional Feature:
- Macro: NAND_CHK_FIRST_FAIL_EN.
- Defined: two extra outputs are added:
  - first_fail_vld (1 bit)
  - first_fail_vec (2 bits)
- On the first mismatch of a run, first_fail_vec captures vec_idx and first_fail_vld is set.
- Later mismatches do not overwrite the capture.
- Both outputs are cleared on reset and on start acceptance.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Correct NAND model on c1, SETTLE_CYCLES=1, REPEAT=1, one start pulse:
  - w1w2 sequence 00, 01, 10, 11.
  - done rises 13 cycles after start is accepted.
  - err_count=0, pass=1.
- c1 tied to 1 (stuck-at-1):
  - Vector 11 mismatches; err_count=1, pass=0.
  - With NAND_CHK_FIRST_FAIL_EN defined: first_fail_vec=3, first_fail_vld=1.
- c1 wired as AND, REPEAT=3:
  - err_count=12, pass=0.
  - With ERR_W=3: err_count saturates at 7.
- SETTLE_CYCLES=0, correct model:
  - done rises 9 cycles after start.
  - start pulses during busy are ignored (done rises once).
  - pass=1.
- rst asserted asynchronously mid-SETTLE on vector 2:
  - All outputs return to reset values immediately; done never rises.
  - A new start afterwards completes with pass=1.
- c1 driven X throughout:
  - err_count=4, pass=0.
  - A second start from DONE clears err_count to 0 on acceptance.
